// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the toggle req/ack bus handshake receiver.
// Holds the receive FSM state encoding, the synchroniser depth floor and
// a small helper that detects a pending request from the two toggle phases.
package cdc_hs_pkg;

    // Receive-side FSM: waiting for a request, or holding a word for the consumer
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } cdc_hs_rx_state_t;

    // Fewest synchroniser flops that still give an acceptable MTBF
    localparam int MIN_SYNC_STAGE = 2;

    // A request is outstanding whenever the synchronised toggle phase differs
    // from the phase of the last word we took.
    function automatic logic req_pending(input logic req_sync, input logic req_seen);
        return req_sync ^ req_seen;
    endfunction

endpackage

// File: rtl/cdc_handshake_rx.sv
// Receive end of a two-phase (toggle) req/ack bus crossing into the clk domain.
//
// The transmitter flips rx_req_tgl once per word and keeps rx_data stable until
// rx_ack_tgl returns to the same phase. The request toggle passes through a
// resettable synchroniser chain; only once the synchronised phase shows a new
// request is rx_data sampled, so the bus is guaranteed settled by then. The word
// is offered on a valid/ready stream and the acknowledge toggle is returned.
//
// Build option:
//   CDC_HS_RX_EARLY_ACK_EN  defined   -> ack toggles on the capture edge, letting
//                                        the transmitter prepare the next word while
//                                        the consumer stalls.
//                           undefined -> ack toggles on the accept edge (full
//                                        backpressure to the transmitter).
//
// Implementation constraints: rx_req_tgl and rx_data are asynchronous to clk and
// need a set_max_delay of one destination clock period (minimum period) on their
// paths into this block. The synchroniser flops carry ASYNC_REG so placement
// keeps them together.
module cdc_handshake_rx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SYNC_STAGE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_req_tgl,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ack_tgl,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    // Shallower chains give too short an MTBF; refuse to build them.
    if (SYNC_STAGE < MIN_SYNC_STAGE) begin : g_sync_stage_check
        $error("cdc_handshake_rx: SYNC_STAGE must be at least MIN_SYNC_STAGE");
    end

    // ------------------------------------------------------------------
    // Request synchroniser
    // Kept inline rather than using a generic synchroniser cell because the
    // chain must clear on the synchronous reset so both ends restart at phase 0.
    // ------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] req_sync_r;
    logic                                           req_sync_s;

    // Shift the asynchronous request toggle through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync_r <= {SYNC_STAGE{1'b0}};
        end else begin
            req_sync_r <= {req_sync_r[SYNC_STAGE-2:0], rx_req_tgl};
        end
    end

    assign req_sync_s = req_sync_r[SYNC_STAGE-1];

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    cdc_hs_rx_state_t        state_r;
    logic                    req_seen_r;
    logic                    ack_r;
    logic                    m_valid_r;
    logic [DATA_WIDTH-1:0]   m_data_r;
    logic                    new_req_s;
    logic                    accept_s;

    // A new word is waiting once the synchronised phase moves past the last one taken
    assign new_req_s = req_pending(req_sync_s, req_seen_r);

    // Consumer handshake; m_ready alone means nothing while no word is held
    assign accept_s  = m_valid_r & m_ready;

    // Capture, hold and release words, and return the acknowledge toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            req_seen_r <= 1'b0;
            ack_r      <= 1'b0;
            m_valid_r  <= 1'b0;
            m_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // rx_data is only sampled here, after the toggle has been
                    // synchronised, so the transmitter's bus is already settled.
                    if (new_req_s) begin
                        m_data_r   <= rx_data;
                        m_valid_r  <= 1'b1;
                        req_seen_r <= req_sync_s;
                        state_r    <= VALID;
`ifdef CDC_HS_RX_EARLY_ACK_EN
                        // Word is safely held in m_data; release the transmitter now.
                        ack_r      <= ~ack_r;
`endif
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                VALID: begin
                    // A request that is already pending is left for the next
                    // edge: leaving VALID always costs one idle cycle.
                    if (accept_s) begin
                        m_valid_r  <= 1'b0;
                        state_r    <= IDLE;
`ifndef CDC_HS_RX_EARLY_ACK_EN
                        // Transmitter has been holding rx_data until now.
                        ack_r      <= ~ack_r;
`endif
                    end else begin
                        state_r    <= VALID;
                    end
                end
                default: begin
                    // Unreachable encoding: drop any word and return to a safe idle.
                    state_r    <= IDLE;
                    m_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops; nothing combinational toward the tx domain.
    assign rx_ack_tgl = ack_r;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx (DATA_WIDTH=32, SYNC_STAGE=3).
// A transaction-level model tracks the words the transmitter has sent and the
// number the consumer has taken; from those it derives, every cycle, what
// m_valid/m_data/rx_ack_tgl must be. Directed steps add literal expectations
// for reset, latency, backpressure and the ack timing of the selected build.
module tb_cdc_handshake_rx;

    localparam int DW = 32;
    localparam int SS = 3;

    logic          clk;
    logic          reset;
    logic          rx_req_tgl;
    logic [DW-1:0] rx_data;
    logic          rx_ack_tgl;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    int            checks = 0;
    int            errors = 0;

    // Model state: words sent and not yet taken, words taken since reset
    logic [DW-1:0] exp_q[$];
    int            acc_cnt    = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          tx_phase   = 1'b0;
    logic          tx_done    = 1'b0;
    int            acc0;

    cdc_handshake_rx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGE (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_req_tgl (rx_req_tgl),
        .rx_data    (rx_data),
        .rx_ack_tgl (rx_ack_tgl),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transmitter model: wait for ack to match our phase, then present a word and toggle.
    // Called at a negedge; returns at a negedge.
    task automatic tx_send(input logic [DW-1:0] w);
        int n;
        n = 0;
        while (rx_ack_tgl !== tx_phase && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ack_wait", 32'(rx_ack_tgl), 32'(tx_phase));
        exp_q.push_back(w);
        rx_data    = w;
        tx_phase   = ~tx_phase;
        rx_req_tgl = tx_phase;
    endtask

    // Per-cycle comparison against the transaction model, just after each edge
    initial begin
        logic exp_ack;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                acc_cnt = 0;
                check("rst_valid", 32'(m_valid), 32'd0);
                check("rst_data", m_data, 32'd0);
                check("rst_ack", 32'(rx_ack_tgl), 32'd0);
            end else begin
                if (prev_valid && m_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    acc_cnt++;
                end
                if (prev_valid && !m_ready) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", m_data, prev_data);
                end
                if (m_valid) begin
                    check("valid_has_word", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("order_data", m_data, exp_q[0]);
                end
`ifdef CDC_HS_RX_EARLY_ACK_EN
                exp_ack = 1'((acc_cnt + (m_valid ? 1 : 0)) % 2);
`else
                exp_ack = 1'(acc_cnt % 2);
`endif
                check("ack_phase", 32'(rx_ack_tgl), 32'(exp_ack));
            end
            prev_valid = m_valid;
            prev_data  = m_data;
        end
    end

    // Global time bound so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        rx_req_tgl = 1'b0;
        rx_data    = '0;
        m_ready    = 1'b0;

        // 1: reset for two edges, then idle with nothing to capture
        repeat (2) @(negedge clk);
        check("t1_valid", 32'(m_valid), 32'd0);
        check("t1_data", m_data, 32'd0);
        check("t1_ack", 32'(rx_ack_tgl), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t1_no_capture", 32'(m_valid), 32'd0);

        // 2: single word, latency SYNC_STAGE edges after first sampling the toggle
        m_ready = 1'b1;
        tx_send(32'hA5A5_1234);
        repeat (3) @(negedge clk);
        check("t2_not_yet", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("t2_valid", 32'(m_valid), 32'd1);
        check("t2_data", m_data, 32'hA5A5_1234);
`ifdef CDC_HS_RX_EARLY_ACK_EN
        check("t2_ack_capture", 32'(rx_ack_tgl), 32'd1);
`else
        check("t2_ack_capture", 32'(rx_ack_tgl), 32'd0);
`endif
        @(negedge clk);
        check("t2_accepted", 32'(m_valid), 32'd0);
        check("t2_ack_done", 32'(rx_ack_tgl), 32'd1);

        // 3/4: backpressure for 20 cycles
        m_ready = 1'b0;
        tx_send(32'h0BAD_F00D);
        repeat (4) @(negedge clk);
        check("t3_valid", 32'(m_valid), 32'd1);
        check("t3_data", m_data, 32'h0BAD_F00D);
`ifdef CDC_HS_RX_EARLY_ACK_EN
        check("t4_ack_early", 32'(rx_ack_tgl), 32'd0);
        tx_send(32'h1111_2222);
`else
        check("t3_ack_held", 32'(rx_ack_tgl), 32'd1);
`endif
        repeat (20) @(negedge clk);
        check("t3_stall_data", m_data, 32'h0BAD_F00D);
        check("t3_stall_valid", 32'(m_valid), 32'd1);
`ifdef CDC_HS_RX_EARLY_ACK_EN
        check("t4_stall_ack", 32'(rx_ack_tgl), 32'd0);
`else
        check("t3_stall_ack", 32'(rx_ack_tgl), 32'd1);
`endif
        m_ready = 1'b1;
        @(negedge clk);
        check("t3_accept", 32'(m_valid), 32'd0);
        check("t3_ack_after", 32'(rx_ack_tgl), 32'd0);
        @(negedge clk);
`ifdef CDC_HS_RX_EARLY_ACK_EN
        check("t4_second_valid", 32'(m_valid), 32'd1);
        check("t4_second_data", m_data, 32'h1111_2222);
        check("t4_second_ack", 32'(rx_ack_tgl), 32'd1);
`else
        check("t3_idle", 32'(m_valid), 32'd0);
`endif
        repeat (3) @(negedge clk);
        m_ready = 1'b0;

        // 5: 100 random words with random consumer readiness
        acc0    = acc_cnt;
        tx_done = 1'b0;
        fork
            begin
                int n;
                for (int i = 0; i < 100; i++) begin
                    tx_send($urandom);
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                n = 0;
                while (exp_q.size() != 0 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_drained", 32'(exp_q.size()), 32'd0);
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        check("t5_count", 32'(acc_cnt - acc0), 32'd100);
        m_ready = 1'b0;
        @(negedge clk);

        // 6: reset while holding a word, then resume with both ends at phase 0
        tx_send(32'h6666_0001);
        repeat (4) @(negedge clk);
        check("t6_valid", 32'(m_valid), 32'd1);
        reset      = 1'b1;
        rx_req_tgl = 1'b0;
        tx_phase   = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_data", m_data, 32'd0);
        check("t6_rst_ack", 32'(rx_ack_tgl), 32'd0);
        reset   = 1'b0;
        m_ready = 1'b1;
        tx_send(32'hCAFE_0006);
        repeat (4) @(negedge clk);
        check("t6_next_valid", 32'(m_valid), 32'd1);
        check("t6_next_data", m_data, 32'hCAFE_0006);
        @(negedge clk);
        check("t6_next_accept", 32'(m_valid), 32'd0);
        check("t6_next_ack", 32'(rx_ack_tgl), 32'd1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
